// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy game blocks: FSM state encoding and the
// default screen geometry used by the bird, renderer and pipe generator.
package flappy_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RISE = 2'd1,
    S_FALL = 2'd2,
    S_DEAD = 2'd3
  } state_t;

  localparam int unsigned SCR_Y_START = 240;
  localparam int unsigned SCR_Y_MIN   = 0;
  localparam int unsigned SCR_Y_MAX   = 460;

endpackage

// File: rtl/bird_motion_ctrl_if.sv
// Bird motion bus: frame/button/collision inputs towards the controller and
// the registered bird position/status (plus FSM state for observation) back.
interface bird_motion_ctrl_if
  import flappy_pkg::*;
#(
  parameter int unsigned Y_WIDTH = 10
);

  // All inputs are single-cycle, clk-synchronous pulses or levels with no
  // handshake: frame_tick and one_shot_button are acted on in the cycle they
  // are high, collision is sampled every cycle; outputs update 1 clock later.
  logic               frame_tick;
  logic               one_shot_button;
  logic               collision;
  logic [Y_WIDTH-1:0] bird_y;
  logic               en_subiendo;
  logic               playing;
  logic               game_over;
  state_t             dbg_state;

  modport master (
    output frame_tick, one_shot_button, collision,
    input  bird_y, en_subiendo, playing, game_over, dbg_state
  );

  modport slave (
    input  frame_tick, one_shot_button, collision,
    output bird_y, en_subiendo, playing, game_over, dbg_state
  );

endinterface

// File: rtl/bird_motion_ctrl_timer.sv
// bird_rise_timer: 8-bit down-counter timing the rise window of one jump.
// o_time_out is high in the decrement cycle that takes the count from 1 to 0.
module bird_rise_timer #(
  parameter int unsigned RISE_FRAMES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_time_out
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= 8'(RISE_FRAMES);
    end else if (i_dec && (r_cnt != 8'd0)) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_time_out = i_dec && (r_cnt == 8'd1);

endmodule

// File: rtl/bird_motion_ctrl.sv
// Bird vertical motion and game lifecycle FSM (IDLE/RISE/FALL/DEAD).
// Optional macro BIRD_GRAVITY_ACCEL_EN: fall speed grows by 1 per frame up to FALL_MAX.
module bird_motion_ctrl
  import flappy_pkg::*;
#(
  parameter int unsigned Y_WIDTH     = 10,
  parameter int unsigned Y_START     = SCR_Y_START,
  parameter int unsigned Y_MIN       = SCR_Y_MIN,
  parameter int unsigned Y_MAX       = SCR_Y_MAX,
  parameter int unsigned RISE_STEP   = 4,
  parameter int unsigned FALL_STEP   = 2,
  parameter int unsigned FALL_MAX    = 8,
  parameter int unsigned RISE_FRAMES = 8
) (
  input logic               clk,
  input logic               rst,
  bird_motion_ctrl_if.slave bus
);

  localparam int unsigned SPD_W = $clog2(FALL_MAX + 1);

  state_t             r_state;
  state_t             w_next;
  logic [Y_WIDTH-1:0] r_y;
  logic [Y_WIDTH-1:0] w_y_next;
  logic [Y_WIDTH-1:0] w_rise_y;
  logic [Y_WIDTH:0]   w_sum;
  logic [SPD_W-1:0]   w_speed;
  logic               w_floor;
  logic               w_load;
  logic               w_time_out;

  // Extra MSB on the sum so a large fall step near the floor cannot wrap.
  assign w_sum    = {1'b0, r_y} + (Y_WIDTH + 1)'(w_speed);
  assign w_floor  = (r_state == S_FALL) && bus.frame_tick &&
                    (w_sum >= (Y_WIDTH + 1)'(Y_MAX));
  assign w_rise_y = ({1'b0, r_y} >= (Y_WIDTH + 1)'(Y_MIN + RISE_STEP)) ?
                    (r_y - Y_WIDTH'(RISE_STEP)) : Y_WIDTH'(Y_MIN);
  assign w_load   = bus.one_shot_button && (w_next == S_RISE);

  bird_rise_timer #(.RISE_FRAMES(RISE_FRAMES)) u_rise_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_dec      (bus.frame_tick && (r_state == S_RISE)),
    .o_time_out (w_time_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_y     <= Y_WIDTH'(Y_START);
    end else begin
      r_state <= w_next;
      r_y     <= w_y_next;
    end
  end

  // Priority inside a live game: collision, floor, button, rise expiry.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (bus.one_shot_button) w_next = S_RISE;
      S_RISE, S_FALL: begin
        if (bus.collision || w_floor) w_next = S_DEAD;
        else if (bus.one_shot_button) w_next = S_RISE;
        else if (w_time_out)          w_next = S_FALL;
      end
      S_DEAD: if (bus.one_shot_button) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_y_next = r_y;
    unique case (r_state)
      S_IDLE: w_y_next = Y_WIDTH'(Y_START);
      S_RISE: if (bus.frame_tick && !bus.collision) w_y_next = w_rise_y;
      S_FALL: if (bus.frame_tick && !bus.collision)
                w_y_next = w_floor ? Y_WIDTH'(Y_MAX) : w_sum[Y_WIDTH-1:0];
      S_DEAD: if (bus.one_shot_button) w_y_next = Y_WIDTH'(Y_START);
      default: w_y_next = r_y;
    endcase
  end

  always_comb begin
    bus.en_subiendo = 1'b0;
    bus.playing     = 1'b0;
    bus.game_over   = 1'b0;
    unique case (r_state)
      S_RISE: begin
        bus.en_subiendo = 1'b1;
        bus.playing     = 1'b1;
      end
      S_FALL:  bus.playing   = 1'b1;
      S_DEAD:  bus.game_over = 1'b1;
      default: bus.playing   = 1'b0;
    endcase
  end

  assign bus.bird_y    = r_y;
  assign bus.dbg_state = r_state;

`ifdef BIRD_GRAVITY_ACCEL_EN
  logic [SPD_W-1:0] r_speed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_speed <= SPD_W'(FALL_STEP);
    end else if ((r_state != S_FALL) && (w_next == S_FALL)) begin
      r_speed <= SPD_W'(FALL_STEP);
    end else if ((r_state == S_FALL) && bus.frame_tick && (r_speed < SPD_W'(FALL_MAX))) begin
      r_speed <= r_speed + SPD_W'(1);
    end
  end

  assign w_speed = r_speed;
`else
  assign w_speed = SPD_W'(FALL_STEP);
`endif

endmodule

// File: doc/bird_motion_ctrl.md
# bird_motion_ctrl

Sequences the bird's vertical motion and the game lifecycle. It sits between the debounced one-shot jump button and the VGA sprite renderer. Per video frame it advances the bird's Y coordinate: rising for a fixed number of frames after each jump, then falling under gravity. It ends the game on a collision or when the bird hits the floor.

## Interface
- `Y_WIDTH`, default 10: width of the Y coordinate.
- `Y_START`, default 240: Y value on reset and on restart.
- `Y_MIN`, default 0: ceiling. Rise saturates here.
- `Y_MAX`, default 460: floor. Reaching it ends the game.
- `RISE_STEP`, default 4: pixels subtracted per frame while rising.
- `FALL_STEP`, default 2: base pixels added per frame while falling.
- `FALL_MAX`, default 8: fall-speed ceiling (used only with acceleration enabled).
- `RISE_FRAMES`, default 8: frames spent rising per jump, 1..255.
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: synchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse per video frame. It is the only motion time base.
- `one_shot_button` in 1: one-cycle jump/start pulse.
- `collision` in 1: level-sensitive pipe-hit flag from the renderer.
- `bird_y` out `Y_WIDTH`: current top Y of the sprite. Registered.
- `en_subiendo` out 1: high while in RISE.
- `playing` out 1: high in RISE or FALL.
- `game_over` out 1: high in DEAD.

## Operation
- States: IDLE, RISE, FALL, DEAD. `playing`, `game_over` and `en_subiendo` are decoded from registered state; no combinational path from inputs to outputs.
- IDLE:
  - `bird_y` is held at `Y_START`.
  - `one_shot_button` -> RISE, load `rise_cnt` = `RISE_FRAMES`.
- RISE, on each `frame_tick`:
  - `bird_y` = max(`bird_y` − `RISE_STEP`, `Y_MIN`), computed without underflow.
  - `rise_cnt` decrements. When `rise_cnt` decrements 1 -> 0: go to FALL, reset fall speed to `FALL_STEP`.
- FALL, on each `frame_tick`:
  - `bird_y` += fall speed.
  - If the result is ≥ `Y_MAX`: `bird_y` = `Y_MAX`, go to DEAD.
  - The sum is computed at `Y_WIDTH`+1 bits, so there is no wrap-around.
- Jump in RISE or FALL: `one_shot_button` -> RISE and reload `rise_cnt` = `RISE_FRAMES`. A jump while rising restarts the rise window.
- `collision` high in RISE or FALL -> DEAD on the next edge. `bird_y` freezes at its current value. `collision` is ignored in IDLE and DEAD.
- DEAD:
  - `bird_y` is held.
  - `one_shot_button` -> IDLE, `bird_y` = `Y_START`.
  - A second button press is needed to start a new game.
- Simultaneous events, in priority order:
  1. `rst`
  2. `collision`
  3. floor hit
  4. `one_shot_button`
  5. `rise_cnt` expiry
- Button and `frame_tick` in the same cycle: the position step uses the current state's rule, and the state/counter update from the button takes effect at the same edge. Example: in FALL, the fall step is applied, then the next state is RISE with `rise_cnt` = `RISE_FRAMES`.
- Button in FALL in the same cycle as a tick that reaches the floor: floor wins, DEAD.

## Timing
- Reset values:
  - state = IDLE
  - `bird_y` = `Y_START`
  - `rise_cnt` = 0
  - fall speed = `FALL_STEP`
  - `en_subiendo` = 0, `playing` = 0, `game_over` = 0
- Latency from any input pulse to the corresponding output change: 1 clock.
- `bird_y` changes at most once per `frame_tick`, one cycle after the tick.
- `rst` asserted mid-game returns everything to reset values at the next edge, regardless of the other inputs.
- Inputs are assumed synchronous to `clk`. `frame_tick` spacing is ≥ 2 cycles.

## Configuration
- `BIRD_GRAVITY_ACCEL_EN` defined:
  - In FALL, fall speed increments by 1 after each `frame_tick` step, saturating at `FALL_MAX`.
  - Fall speed resets to `FALL_STEP` on every entry to FALL.
- `BIRD_GRAVITY_ACCEL_EN` undefined:
  - Fall speed is the constant `FALL_STEP`.
  - `FALL_MAX` is unused, and no speed register is synthesized.

## Structure
- Shared package `flappy_pkg` holds:
  - the state encoding (IDLE=0, RISE=1, FALL=2, DEAD=3)
  - default screen geometry constants (`Y_START`, `Y_MIN`, `Y_MAX`), shared with the renderer and pipe generator.
- One sub-module, `bird_rise_timer`: an 8-bit down-counter.
  - Inputs: `load` (value `RISE_FRAMES`), decrement enable `frame_tick & en_subiendo`.
  - Output: one-cycle `time_out` when the count goes 1 -> 0.
- The controller FSM and the Y datapath stay in `bird_motion_ctrl`.

## Test plan
- **Reset / idle**: `rst` for 2 cycles, then 10 ticks with no button -> `bird_y` = 240, `playing` = 0, `game_over` = 0 throughout.
- **Rise window**: button in IDLE, then 8 ticks -> `en_subiendo` = 1 for exactly the 8 ticks, `bird_y` = 240 − 32 = 208, state FALL after the 8th tick.
- **Re-jump and ceiling**: `Y_START` = 6, button, 1 tick -> `bird_y` = 2. Button again, 3 ticks -> `bird_y` = 0 (saturated), `rise_cnt` reloaded so still in RISE.
- **Floor death, constant gravity** (macro undefined): start FALL at `bird_y` = 455, 3 ticks -> 457, 459, then 460 = `Y_MAX` and `game_over` = 1. Further ticks leave 460.
- **Acceleration** (macro defined): fall from `bird_y` = 100 for 4 ticks -> 102, 105, 109, 114. Speed caps at 8 on later ticks.
- **Collision priority and restart**: `collision` and button in the same cycle during FALL -> DEAD, `bird_y` frozen. Next button -> IDLE with `bird_y` = 240. `rst` pulse mid-RISE -> all reset values next edge.
